// File: rtl/mem_bus_ctrl_pkg.sv
// rtl/mem_bus_ctrl_pkg.sv - shared bus types, tag-table entry and helpers for mem_bus_ctrl
package mem_bus_ctrl_pkg;

  localparam int XLEN     = 32;
  localparam int TAG_W    = 4;
  localparam int TAG_ID_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } mem_size_e;

  typedef enum logic {
    CLIENT_DC = 1'b0,
    CLIENT_IC = 1'b1
  } client_e;

  // Client IDs wider than TAG_ID_W are not carried through the table.
  typedef struct packed {
    logic                valid;
    client_e             client;
    logic [TAG_ID_W-1:0] id;
  } tag_entry_t;

  function automatic logic [3:0] count_valid(input logic [15:1] v);
    logic [3:0] n;
    n = '0;
    for (int i = 1; i <= 15; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_tag_table.sv
// rtl/mem_bus_ctrl_tag_table.sv - 15-entry in-flight load table, one write port, one read-and-clear port
module mem_tag_table
  import mem_bus_ctrl_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  tag_entry_t       i_wr_entry,
  input  logic [TAG_W-1:0] i_rd_tag,
  output tag_entry_t       o_rd_entry,
  output logic [15:1]      o_valid
);

  tag_entry_t r_tbl [1:15];

  // The write follows the clear so a same-tag accept overrides the retiring entry.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 1; i <= 15; i++) r_tbl[i] <= '0;
    end else begin
      if (i_rd_tag != '0) r_tbl[i_rd_tag].valid <= 1'b0;
      if (i_wr_en && (i_wr_tag != '0)) r_tbl[i_wr_tag] <= i_wr_entry;
    end
  end

  assign o_rd_entry = (i_rd_tag != '0) ? r_tbl[i_rd_tag] : '0;

  always_comb begin
    o_valid = '0;
    for (int i = 1; i <= 15; i++) o_valid[i] = r_tbl[i].valid;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - tagged memory bus initiator for dcache/icache; MEM_BUS_RR_ARB_EN selects round-robin grant
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dc_req_valid,
  input  bus_command_e     dc_req_cmd,
  input  logic [XLEN-1:0]  dc_req_addr,
  input  logic [63:0]      dc_req_data,
  input  mem_size_e        dc_req_size,
  input  logic [ID_W-1:0]  dc_req_id,
  output logic             dc_req_ready,
  input  logic             ic_req_valid,
  input  logic [XLEN-1:0]  ic_req_addr,
  input  logic [ID_W-1:0]  ic_req_id,
  output logic             ic_req_ready,
  output logic             dc_resp_valid,
  output logic [63:0]      dc_resp_data,
  output logic [ID_W-1:0]  dc_resp_id,
  output logic             ic_resp_valid,
  output logic [63:0]      ic_resp_data,
  output logic [ID_W-1:0]  ic_resp_id,
  output bus_command_e     proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output mem_size_e        proc2mem_size,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output logic [3:0]       outstanding,
  output logic             tag_err
);

  logic            r_ir_valid;
  client_e         r_ir_client;
  bus_command_e    r_ir_cmd;
  logic [XLEN-1:0] r_ir_addr;
  logic [63:0]     r_ir_data;
  mem_size_e       r_ir_size;
  logic [ID_W-1:0] r_ir_id;

  logic            r_dc_resp_valid, r_ic_resp_valid, r_tag_err;
  logic [63:0]     r_dc_resp_data, r_ic_resp_data;
  logic [ID_W-1:0] r_dc_resp_id, r_ic_resp_id;

  logic       w_accept, w_free, w_prefer_dc, w_gnt_dc, w_gnt_ic, w_hit;
  tag_entry_t w_wr_entry, w_rd_entry;
  logic [15:1] w_valid;

  assign w_accept = r_ir_valid && (mem2proc_response != '0);
  assign w_free   = !r_ir_valid || w_accept;

`ifdef MEM_BUS_RR_ARB_EN
  // Remembers the winner of the last two-way conflict; the other client wins the next one.
  client_e r_last_gnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_last_gnt <= CLIENT_IC;
    else if (dc_req_valid && ic_req_valid && w_free)
      r_last_gnt <= w_gnt_ic ? CLIENT_IC : CLIENT_DC;
  end
  assign w_prefer_dc = (r_last_gnt == CLIENT_IC);
`else
  assign w_prefer_dc = 1'b1;
`endif

  assign w_gnt_dc     = dc_req_valid && (!ic_req_valid || w_prefer_dc);
  assign w_gnt_ic     = ic_req_valid && (!dc_req_valid || !w_prefer_dc);
  assign dc_req_ready = w_free && w_gnt_dc;
  assign ic_req_ready = w_free && w_gnt_ic;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ir_valid  <= 1'b0;
      r_ir_client <= CLIENT_DC;
      r_ir_cmd    <= BUS_NONE;
      r_ir_addr   <= '0;
      r_ir_data   <= '0;
      r_ir_size   <= SIZE_BYTE;
      r_ir_id     <= '0;
    end else if (dc_req_ready) begin
      r_ir_valid  <= 1'b1;
      r_ir_client <= CLIENT_DC;
      r_ir_cmd    <= dc_req_cmd;
      r_ir_addr   <= dc_req_addr;
      r_ir_data   <= dc_req_data;
      r_ir_size   <= dc_req_size;
      r_ir_id     <= dc_req_id;
    end else if (ic_req_ready) begin
      r_ir_valid  <= 1'b1;
      r_ir_client <= CLIENT_IC;
      r_ir_cmd    <= BUS_LOAD;
      r_ir_addr   <= ic_req_addr;
      r_ir_data   <= '0;
      r_ir_size   <= SIZE_DOUBLE;
      r_ir_id     <= ic_req_id;
    end else if (w_accept) begin
      r_ir_valid  <= 1'b0;
    end
  end

  always_comb begin
    w_wr_entry        = '0;
    w_wr_entry.valid  = 1'b1;
    w_wr_entry.client = r_ir_client;
    w_wr_entry.id     = TAG_ID_W'(r_ir_id);
  end

  mem_tag_table u_tag_table (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_wr_en    (w_accept && (r_ir_cmd == BUS_LOAD)),
    .i_wr_tag   (mem2proc_response),
    .i_wr_entry (w_wr_entry),
    .i_rd_tag   (mem2proc_tag),
    .o_rd_entry (w_rd_entry),
    .o_valid    (w_valid)
  );

  assign w_hit = (mem2proc_tag != '0) && w_rd_entry.valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dc_resp_valid <= 1'b0;
      r_ic_resp_valid <= 1'b0;
      r_dc_resp_data  <= '0;
      r_ic_resp_data  <= '0;
      r_dc_resp_id    <= '0;
      r_ic_resp_id    <= '0;
      r_tag_err       <= 1'b0;
    end else begin
      r_dc_resp_valid <= w_hit && (w_rd_entry.client == CLIENT_DC);
      r_ic_resp_valid <= w_hit && (w_rd_entry.client == CLIENT_IC);
      if (w_hit && (w_rd_entry.client == CLIENT_DC)) begin
        r_dc_resp_data <= mem2proc_data;
        r_dc_resp_id   <= ID_W'(w_rd_entry.id);
      end
      if (w_hit && (w_rd_entry.client == CLIENT_IC)) begin
        r_ic_resp_data <= mem2proc_data;
        r_ic_resp_id   <= ID_W'(w_rd_entry.id);
      end
      if ((mem2proc_tag != '0) && !w_rd_entry.valid) r_tag_err <= 1'b1;
    end
  end

  assign proc2mem_command = r_ir_valid ? r_ir_cmd : BUS_NONE;
  assign proc2mem_addr    = r_ir_addr;
  assign proc2mem_data    = r_ir_data;
  assign proc2mem_size    = r_ir_size;
  assign dc_resp_valid    = r_dc_resp_valid;
  assign dc_resp_data     = r_dc_resp_data;
  assign dc_resp_id       = r_dc_resp_id;
  assign ic_resp_valid    = r_ic_resp_valid;
  assign ic_resp_data     = r_ic_resp_data;
  assign ic_resp_id       = r_ic_resp_id;
  assign outstanding      = count_valid(w_valid);
  assign tag_err          = r_tag_err;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl acting as the memory responder
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  localparam int ID_W = 4;
`ifdef MEM_BUS_RR_ARB_EN
  localparam bit FIXED_PRIO = 1'b0;
`else
  localparam bit FIXED_PRIO = 1'b1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dc_req_valid, ic_req_valid, dc_req_ready, ic_req_ready;
  bus_command_e dc_req_cmd, proc2mem_command;
  logic [XLEN-1:0] dc_req_addr, ic_req_addr, proc2mem_addr;
  logic [63:0] dc_req_data, proc2mem_data, mem2proc_data;
  mem_size_e dc_req_size, proc2mem_size;
  logic [ID_W-1:0] dc_req_id, ic_req_id, dc_resp_id, ic_resp_id;
  logic dc_resp_valid, ic_resp_valid, tag_err;
  logic [63:0] dc_resp_data, ic_resp_data;
  logic [3:0] mem2proc_response, mem2proc_tag, outstanding;

  mem_bus_ctrl #(.ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .dc_req_valid(dc_req_valid), .dc_req_cmd(dc_req_cmd), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_size(dc_req_size), .dc_req_id(dc_req_id),
    .dc_req_ready(dc_req_ready),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_id(ic_req_id),
    .ic_req_ready(ic_req_ready),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .dc_resp_id(dc_resp_id),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data), .ic_resp_id(ic_resp_id),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag), .outstanding(outstanding), .tag_err(tag_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    client_e         client;
    bus_command_e    cmd;
    logic [XLEN-1:0] addr;
    logic [63:0]     data;
    mem_size_e       size;
    logic [ID_W-1:0] id;
  } req_t;

  typedef struct {
    int              cyc;
    logic [63:0]     data;
    logic [ID_W-1:0] id;
  } resp_t;

  req_t  iq[$];
  resp_t dc_q[$];
  resp_t ic_q[$];
  bit              m_valid [16];
  client_e         m_client[16];
  logic [ID_W-1:0] m_id    [16];
  bit exp_err;
  bit m_last_ic;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    iq.delete(); dc_q.delete(); ic_q.delete();
    for (int t = 0; t < 16; t++) m_valid[t] = 1'b0;
    exp_err   = 1'b0;
    m_last_ic = 1'b1;
  endtask

  function automatic bit prefer_dc();
    return FIXED_PRIO | m_last_ic;
  endfunction

  function automatic int n_valid();
    int n = 0;
    for (int t = 1; t < 16; t++) n += int'(m_valid[t]);
    return n;
  endfunction

  task automatic check_comb();
    bit free, gdc, gic;
    free = (iq.size() == 0) || (mem2proc_response != 4'd0);
    gdc  = dc_req_valid && (!ic_req_valid || prefer_dc());
    gic  = ic_req_valid && (!dc_req_valid || !prefer_dc());
    chk("dc_req_ready", dc_req_ready, free && gdc);
    chk("ic_req_ready", ic_req_ready, free && gic);
    if (iq.size() != 0) begin
      chk("bus_cmd", proc2mem_command, iq[0].cmd);
      chk("bus_addr", proc2mem_addr, iq[0].addr);
      chk("bus_size", proc2mem_size, iq[0].size);
      if (iq[0].cmd == BUS_STORE) chk("bus_data", proc2mem_data, iq[0].data);
    end else begin
      chk("bus_cmd_idle", proc2mem_command, BUS_NONE);
    end
    if (reset) begin
      chk("rst_addr", proc2mem_addr, 0);
      chk("rst_data", proc2mem_data, 0);
      chk("rst_size", proc2mem_size, 0);
    end
    chk("outstanding", outstanding, n_valid());
    chk("tag_err", tag_err, exp_err);
  endtask

  task automatic update_model();
    bit free, accept, gdc, gic;
    req_t r;
    if (reset) begin
      model_reset();
      return;
    end
    free   = (iq.size() == 0) || (mem2proc_response != 4'd0);
    accept = (iq.size() != 0) && (mem2proc_response != 4'd0);
    gdc    = dc_req_valid && (!ic_req_valid || prefer_dc());
    gic    = ic_req_valid && (!dc_req_valid || !prefer_dc());
    if (mem2proc_tag != 4'd0) begin
      if (m_valid[mem2proc_tag]) begin
        if (m_client[mem2proc_tag] == CLIENT_DC)
          dc_q.push_back('{cyc + 1, mem2proc_data, m_id[mem2proc_tag]});
        else
          ic_q.push_back('{cyc + 1, mem2proc_data, m_id[mem2proc_tag]});
        m_valid[mem2proc_tag] = 1'b0;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (accept) begin
      r = iq.pop_front();
      if (r.cmd == BUS_LOAD) begin
        m_valid[mem2proc_response]  = 1'b1;
        m_client[mem2proc_response] = r.client;
        m_id[mem2proc_response]     = r.id;
      end
    end
    if (free) begin
      if (gdc)
        iq.push_back('{CLIENT_DC, dc_req_cmd, dc_req_addr, dc_req_data, dc_req_size, dc_req_id});
      else if (gic)
        iq.push_back('{CLIENT_IC, BUS_LOAD, ic_req_addr, 64'd0, SIZE_DOUBLE, ic_req_id});
      if (dc_req_valid && ic_req_valid) m_last_ic = gic;
    end
  endtask

  // Response monitor: pops expectations whose due cycle has arrived.
  always @(negedge clock) begin
    if (dc_q.size() != 0 && dc_q[0].cyc == cyc) begin
      chk("dc_resp_valid", dc_resp_valid, 1);
      chk("dc_resp_data", dc_resp_data, dc_q[0].data);
      chk("dc_resp_id", dc_resp_id, dc_q[0].id);
      void'(dc_q.pop_front());
    end else begin
      chk("dc_resp_idle", dc_resp_valid, 0);
    end
    if (ic_q.size() != 0 && ic_q[0].cyc == cyc) begin
      chk("ic_resp_valid", ic_resp_valid, 1);
      chk("ic_resp_data", ic_resp_data, ic_q[0].data);
      chk("ic_resp_id", ic_resp_id, ic_q[0].id);
      void'(ic_q.pop_front());
    end else begin
      chk("ic_resp_idle", ic_resp_valid, 0);
    end
  end

  task automatic step();
    @(negedge clock);
    check_comb();
    update_model();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dc_req_valid = 1'b0; ic_req_valid = 1'b0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
  endtask

  task automatic dc_req(input bus_command_e c, input logic [XLEN-1:0] a, input logic [ID_W-1:0] id);
    dc_req_valid = 1'b1; dc_req_cmd = c; dc_req_addr = a;
    dc_req_data = {$urandom, $urandom}; dc_req_size = SIZE_WORD; dc_req_id = id;
  endtask

  task automatic ic_req(input logic [XLEN-1:0] a, input logic [ID_W-1:0] id);
    ic_req_valid = 1'b1; ic_req_addr = a; ic_req_id = id;
  endtask

  function automatic logic [3:0] pick_free(input logic [3:0] ret);
    int c[$];
    for (int t = 1; t < 16; t++) if (!m_valid[t] || t == int'(ret)) c.push_back(t);
    if (c.size() == 0) return 4'd0;
    return 4'(c[$urandom_range(c.size() - 1)]);
  endfunction

  function automatic logic [3:0] pick_valid();
    int c[$];
    for (int t = 1; t < 16; t++) if (m_valid[t]) c.push_back(t);
    if (c.size() == 0) return 4'd0;
    return 4'(c[$urandom_range(c.size() - 1)]);
  endfunction

  task automatic step_auto(input int pacc, input int pret);
    mem2proc_tag  = ($urandom_range(99) < pret) ? pick_valid() : 4'd0;
    mem2proc_data = {$urandom, $urandom};
    mem2proc_response = (iq.size() != 0 && $urandom_range(99) < pacc) ? pick_free(mem2proc_tag) : 4'd0;
    step();
  endtask

  task automatic drain();
    int k = 0;
    idle();
    while ((iq.size() != 0 || n_valid() != 0) && k < 80) begin
      step_auto(100, 100);
      k++;
    end
    idle();
    step();
    chk("drain_done", (iq.size() != 0 || n_valid() != 0), 0);
  endtask

  initial begin
    model_reset();
    idle();
    dc_req_cmd = BUS_LOAD; dc_req_addr = '0; dc_req_data = '0; dc_req_size = SIZE_BYTE;
    dc_req_id = '0; ic_req_addr = '0; ic_req_id = '0; mem2proc_data = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single load: accept tag 3, return 0xDEADBEEF ten cycles later.
    dc_req(BUS_LOAD, 32'h100, 4'd5); step();
    idle(); mem2proc_response = 4'd3; step();
    idle(); repeat (9) step();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEADBEEF; step();
    idle(); repeat (2) step();

    // Store retried for four cycles, while the next store waits behind it.
    dc_req(BUS_STORE, 32'h200, 4'd2); step();
    dc_req(BUS_STORE, 32'h300, 4'd3);
    repeat (4) step();
    mem2proc_response = 4'd5; step();
    idle(); mem2proc_response = 4'd6; step();
    idle(); step();

    // Both clients request every cycle, memory accepts every cycle.
    for (int i = 0; i < 10; i++) begin
      dc_req(BUS_STORE, 32'h1000 + 32'(i * 8), 4'(i));
      ic_req(32'h8000 + 32'(i * 8), 4'(i + 3));
      step_auto(100, 30);
    end
    drain();

    // Three loads on tags 1,2,3 returned 3,1,2.
    dc_req(BUS_LOAD, 32'h400, 4'd1); step();
    idle(); ic_req(32'h500, 4'd2); mem2proc_response = 4'd1; step();
    idle(); dc_req(BUS_LOAD, 32'h600, 4'd3); mem2proc_response = 4'd2; step();
    idle(); mem2proc_response = 4'd3; step();
    idle();
    mem2proc_tag = 4'd3; mem2proc_data = 64'h33; step();
    mem2proc_tag = 4'd1; mem2proc_data = 64'h11; step();
    mem2proc_tag = 4'd2; mem2proc_data = 64'h22; step();
    idle(); repeat (2) step();

    // Tag 7 returns in the same cycle it is re-accepted for a new load.
    dc_req(BUS_LOAD, 32'h700, 4'd4); step();
    idle(); ic_req(32'h740, 4'd9); mem2proc_response = 4'd7; step();
    idle(); mem2proc_response = 4'd7; mem2proc_tag = 4'd7; mem2proc_data = 64'h7777; step();
    idle(); step();
    mem2proc_tag = 4'd7; mem2proc_data = 64'h7A7A; step();
    idle(); repeat (2) step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      dc_req_valid = 1'($urandom_range(1));
      dc_req_cmd   = $urandom_range(1) ? BUS_LOAD : BUS_STORE;
      dc_req_addr  = $urandom;
      dc_req_data  = {$urandom, $urandom};
      dc_req_size  = mem_size_e'($urandom_range(3));
      dc_req_id    = ID_W'($urandom);
      ic_req_valid = 1'($urandom_range(1));
      ic_req_addr  = $urandom;
      ic_req_id    = ID_W'($urandom);
      step_auto(70, 35);
    end
    drain();

    // Reset with two loads in flight, then a stale return of tag 1.
    dc_req(BUS_LOAD, 32'h900, 4'd1); step();
    idle(); ic_req(32'h940, 4'd2); mem2proc_response = 4'd1; step();
    idle(); mem2proc_response = 4'd2; step();
    idle(); step();
    reset = 1'b1;
    model_reset();
    repeat (2) step();
    reset = 1'b0;
    step();
    mem2proc_tag = 4'd1; mem2proc_data = 64'h1111; step();
    idle(); repeat (3) step();

    chk("dc_q_empty", dc_q.size(), 0);
    chk("ic_q_empty", ic_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
